// File: rtl/multi_unit_pkg.sv
// Shared constants and types for the picoMIPS MULTI fixed-point multiplier.
//   REG_W     : register/result width (two's complement integer)
//   IMM_W     : immediate width (two's complement fixed point)
//   FRAC_BITS : fractional bits of the immediate (Q2.3 by default)
//   PROD_W    : full product width, wide enough that register*immediate never overflows
// Range macros REG_SIZE / IMM_SIZE give the packed ranges of reg_t / imm_t.
`ifndef MULTI_UNIT_PKG_SV
`define MULTI_UNIT_PKG_SV

`define REG_SIZE (REG_W-1):0
`define IMM_SIZE (IMM_W-1):0

package multi_unit_pkg;

   localparam int unsigned REG_W     = 8;
   localparam int unsigned IMM_W     = 5;
   localparam int unsigned FRAC_BITS = 3;
   localparam int unsigned PROD_W    = REG_W + IMM_W;

   typedef logic signed [`REG_SIZE]   reg_t;
   typedef logic signed [`IMM_SIZE]   imm_t;
   typedef logic signed [PROD_W-1:0]  prod_t;

endpackage

`endif

// File: rtl/multi_unit_if.sv
// Operand/result bundle between the ALU datapath and the MULTI unit.
//   in_valid  : operands valid this cycle
//   register  : signed multiplicand (integer)
//   immediate : signed multiplier (fixed point)
//   out_valid : result valid
//   result    : signed scaled product
// master = operand source / result sink, slave = multiplier.
interface multi_unit_if;
   import multi_unit_pkg::*;

   logic in_valid;
   reg_t register;
   imm_t immediate;
   logic out_valid;
   reg_t result;

   modport master (
      output in_valid, register, immediate,
      input  out_valid, result
   );

   modport slave (
      input  in_valid, register, immediate,
      output out_valid, result
   );
endinterface

// File: rtl/multi_unit_core.sv
// Combinational core of the MULTI unit: full signed multiply, arithmetic
// right shift by FRAC_BITS (floor, no rounding), then narrowing to REG_W.
// Narrowing wraps by default; with MULTI_SAT_EN defined it clamps to the
// signed REG_W range first.
//   register_i  : signed multiplicand
//   immediate_i : signed fixed-point multiplier
//   result_c    : scaled, narrowed product (combinational)
module multi_unit_core
   import multi_unit_pkg::*;
(
   input  reg_t register_i,
   input  imm_t immediate_i,
   output reg_t result_c
);

`ifdef MULTI_SAT_EN
   localparam prod_t SAT_MAX = prod_t'((2 ** (REG_W - 1)) - 1);
   localparam prod_t SAT_MIN = prod_t'(-(2 ** (REG_W - 1)));
`endif

   prod_t prod_c;
   prod_t scaled_c;

   // Operands are sign-extended to PROD_W so the product is exact.
   always_comb begin
      prod_c   = prod_t'(register_i) * prod_t'(immediate_i);
      scaled_c = prod_c >>> FRAC_BITS;
`ifdef MULTI_SAT_EN
      if (scaled_c > SAT_MAX) begin
         result_c = reg_t'(SAT_MAX);
      end else if (scaled_c < SAT_MIN) begin
         result_c = reg_t'(SAT_MIN);
      end else begin
         result_c = reg_t'(scaled_c);
      end
`else
      result_c = reg_t'(scaled_c);
`endif
   end

endmodule

// File: rtl/multi_unit.sv
// picoMIPS MULTI unit: signed register x signed fractional immediate,
// product scaled back to register width, registered with 1-cycle latency.
// Optional macro MULTI_SAT_EN selects saturating instead of wrapping narrowing.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high; clears out_valid and result
//   bus   : multi_unit_if.slave (in_valid/register/immediate in,
//           out_valid/result out)
module multi_unit
   import multi_unit_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   multi_unit_if.slave   bus
);

   reg_t core_result_c;
   logic out_valid_d;
   logic out_valid_q;
   reg_t result_d;
   reg_t result_q;

   multi_unit_core u_core (
      .register_i  (bus.register),
      .immediate_i (bus.immediate),
      .result_c    (core_result_c)
   );

   // Capture a new result only on valid operands; otherwise hold it.
   always_comb begin
      out_valid_d = 1'b0;
      result_d    = result_q;
      if (bus.in_valid) begin
         out_valid_d = 1'b1;
         result_d    = core_result_c;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;

endmodule

// File: tb/tb_multi_unit.sv
// Bench for multi_unit: directed boundary cases plus randomized traffic.
// The driver pushes the expected result of every accepted operand pair into
// a queue; an independent monitor pops and compares when out_valid is seen,
// and checks reset clearing and result hold in idle cycles.
module tb_multi_unit;
   import multi_unit_pkg::*;

   typedef struct {
      int         at_edge;
      logic [7:0] res;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   exp_t exp_q[$];

   multi_unit_if bus ();

   multi_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: exact integer product, floor division by 2^FRAC_BITS, then narrow.
   function automatic logic [7:0] model(input logic [7:0] rb, input logic [4:0] ib);
      int r, i, p, den, q;
      r   = $signed(rb);
      i   = $signed(ib);
      p   = r * i;
      den = 1 << FRAC_BITS;
      q   = p / den;
      if (p < 0 && (p % den) != 0) q = q - 1;
`ifdef MULTI_SAT_EN
      if (q > 127)  q = 127;
      if (q < -128) q = -128;
`endif
      return 8'(q);
   endfunction

   task automatic check(input bit ok, input string name, input int act, input int exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic drive(input logic rst, input logic v, input logic [7:0] r, input logic [4:0] i);
      @(posedge clk);
      #1;
      reset         = rst;
      bus.in_valid  = v;
      bus.register  = r;
      bus.immediate = i;
      if (v && !rst) exp_q.push_back('{at_edge: cyc + 1, res: model(r, i)});
   endtask

   // Monitor: reset value is taken at the edge, outputs judged at the following negedge.
   logic       rst_s;
   logic [7:0] hold;
   exp_t       e;
   initial begin
      hold = 8'h00;
      forever begin
         @(posedge clk);
         rst_s = reset;
         @(negedge clk);
         if (rst_s) begin
            check(bus.out_valid === 1'b0, "reset_out_valid", int'(bus.out_valid), 0);
            check(bus.result === 8'h00, "reset_result", int'($signed(bus.result)), 0);
            hold = 8'h00;
         end else if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check(1'b0, "spurious_out_valid", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check(e.at_edge == cyc, "latency_edge", cyc, e.at_edge);
               check(bus.result === e.res, "result",
                     int'($signed(bus.result)), int'($signed(e.res)));
               hold = e.res;
            end
         end else begin
            check(bus.out_valid === 1'b0, "idle_out_valid", int'(bus.out_valid), 0);
            check(bus.result === hold, "hold_result",
                  int'($signed(bus.result)), int'($signed(hold)));
            if (exp_q.size() != 0 && exp_q[0].at_edge <= cyc) begin
               check(1'b0, "missing_out_valid", 0, 1);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   logic [7:0] dr [10] = '{8'd6, 8'd8, 8'h80, 8'hFD, 8'd55, 8'h80, 8'd127, 8'h80, 8'hFF, 8'd1};
   logic [4:0] di [10] = '{5'b00110, 5'b01100, 5'b00100, 5'b00101, 5'b00000,
                          5'b10000, 5'b01111, 5'b01111, 5'b10000, 5'b00111};

   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.register  = '0;
      bus.immediate = '0;
      // Second reset cycle, with operands presented: reset must win.
      drive(1'b1, 1'b1, 8'd6, 5'b00110);
      // Directed cases back to back.
      for (int k = 0; k < 10; k++) drive(1'b0, 1'b1, dr[k], di[k]);
      // Idle: out_valid drops, result holds.
      drive(1'b0, 1'b0, 8'd99, 5'b01010);
      drive(1'b0, 1'b0, 8'd12, 5'b00011);
      // Reset mid-stream discards the pending operand pair.
      drive(1'b0, 1'b1, 8'd100, 5'b01000);
      drive(1'b1, 1'b1, 8'd50, 5'b01000);
      drive(1'b0, 1'b0, 8'd0, 5'b00000);
      drive(1'b0, 1'b1, 8'hF0, 5'b11000);
      // Randomized traffic with occasional resets.
      for (int k = 0; k < 400; k++) begin
         drive(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
               ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
               8'($urandom), 5'($urandom));
      end
      for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 8'($urandom), 5'($urandom));
      @(negedge clk);
      check(exp_q.size() == 0, "drained_queue", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
